free_list: RTL and testbench

- Circular FIFO of free physical register numbers.
- Rename draws new destination pregs from the head; the ROB retire port returns each retiring instruction's old preg to the tail.
- A per-branch snapshot of the head pointer is kept, indexed by ROB tag. On mispredict, pregs allocated after the branch are reclaimed in one cycle.
- The block is the consumer of the ROB retire interface (valid_retired/preg_old) and the supplier of pd_new to rename/dispatch.

---
 rtl/free_list_if.sv | 30 +++
 rtl/free_list.sv | 97 +++++++++
 tb/tb_free_list.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/free_list_if.sv
// Rename / ROB-retire / branch-recovery port bundle of the physical register free list.
// master = rename, ROB and branch unit side; slave = the free list itself.
interface free_list_if #(
  parameter int PREG_W = 7,
  parameter int TAG_W  = 5,
  parameter int CNT_W  = 7
);
  logic              alloc_req;
  logic [PREG_W-1:0] pd_new;
  logic              alloc_valid;
  logic              retire_valid;
  logic [PREG_W-1:0] preg_old;
  logic              ckpt_en;
  logic [TAG_W-1:0]  ckpt_tag;
  logic              mispredict;
  logic [TAG_W-1:0]  mispredict_tag;
  logic [CNT_W-1:0]  free_count;
  logic              full;
  logic              empty;

  modport master (
    output alloc_req, retire_valid, preg_old, ckpt_en, ckpt_tag, mispredict, mispredict_tag,
    input  pd_new, alloc_valid, free_count, full, empty
  );

  modport slave (
    input  alloc_req, retire_valid, preg_old, ckpt_en, ckpt_tag, mispredict, mispredict_tag,
    output pd_new, alloc_valid, free_count, full, empty
  );
endinterface

// File: rtl/free_list.sv
// Circular free list of physical register numbers with per-branch head snapshots.
// Rename pops from the head, retire pushes to the tail, mispredict rewinds the head.
module free_list #(
  parameter int NUM_PREGS = 128,
  parameter int NUM_AREGS = 32,
  parameter int ROB_DEPTH = 16
) (
  input logic        clk,
  input logic        reset,
  free_list_if.slave fl
);
  localparam int DEPTH  = NUM_PREGS - NUM_AREGS;
  localparam int PREG_W = $clog2(NUM_PREGS);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int IDX_W  = $clog2(ROB_DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [PREG_W-1:0] list_q [DEPTH];
  logic [PREG_W-1:0] list_d [DEPTH];
  ptr_t              ckpt_q [ROB_DEPTH];
  ptr_t              ckpt_d [ROB_DEPTH];
  ptr_t              head_q, head_d;
  ptr_t              tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              full, empty;
  logic              do_pop, do_push;
  logic [IDX_W-1:0]  ck_idx, mp_idx;
  ptr_t              ckpt_head, rollback;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    list_d  = list_q;
    ckpt_d  = ckpt_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    ck_idx    = fl.ckpt_tag[IDX_W-1:0];
    mp_idx    = fl.mispredict_tag[IDX_W-1:0];
    ckpt_head = ckpt_q[mp_idx];
    // Distance the head travelled since the snapshot, modulo the ring size.
    rollback  = (head_q >= ckpt_head) ? head_q - ckpt_head
                                      : head_q + ptr_t'(DEPTH) - ckpt_head;

    do_pop  = fl.alloc_req && !empty && !fl.mispredict;
    do_push = fl.retire_valid && (fl.preg_old != '0) && !full;

    if (do_push) begin
      list_d[tail_q] = fl.preg_old;
      tail_d         = ptr_inc(tail_q);
    end

    if (fl.mispredict) begin
      head_d  = ckpt_head;
      count_d = count_q + CNT_W'(rollback) + CNT_W'(do_push);
    end else begin
      if (do_pop) head_d = ptr_inc(head_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      // Snapshot the post-pop head so the branch keeps its own destination preg.
      if (fl.ckpt_en) ckpt_d[ck_idx] = head_d;
    end
  end

  // NOTE: the list storage is reset on purpose: reset must rebuild the initial free set p32..p127.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++)     list_q[i] <= PREG_W'(NUM_AREGS + i);
      for (int j = 0; j < ROB_DEPTH; j++) ckpt_q[j] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CNT_W'(DEPTH);
    end else begin
      list_q  <= list_d;
      ckpt_q  <= ckpt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign fl.pd_new      = list_q[head_q];
  assign fl.alloc_valid = !empty;
  assign fl.free_count  = count_q;
  assign fl.full        = full;
  assign fl.empty       = empty;
endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized traffic
// compared against a queue-based model of free pregs and allocation history.
module tb_free_list;
  localparam int DEPTH = 96;

  logic clk;
  logic reset;

  free_list_if fl ();

  free_list dut (
    .clk   (clk),
    .reset (reset),
    .fl    (fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: free pregs in pop order, history of pops, pop sequence number.
  logic [6:0] free_q[$];
  logic [6:0] pop_log[$];
  int         seq;
  int         ck_seq[16];
  bit         ck_valid[16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    free_q.delete();
    pop_log.delete();
    for (int i = 0; i < DEPTH; i++) free_q.push_back(7'(32 + i));
    seq = 0;
    for (int k = 0; k < 16; k++) begin
      ck_seq[k]   = 0;
      ck_valid[k] = 1'b0;
    end
  endtask

  task automatic model_step(input bit a, input bit rv, input logic [6:0] po, input bit ce,
                            input logic [4:0] ct, input bit mp, input logic [4:0] mt);
    bit push;
    int r;
    push = rv && (po != 7'd0) && (free_q.size() < DEPTH);
    if (mp) begin
      // Every preg allocated after the snapshot becomes free again, in original order.
      r = seq - ck_seq[mt[3:0]];
      for (int k = 0; k < r; k++) free_q.push_front(pop_log.pop_back());
      seq -= r;
    end else begin
      if (a && free_q.size() > 0) begin
        pop_log.push_back(free_q.pop_front());
        seq++;
        if (pop_log.size() > 2 * DEPTH) pop_log.delete(0);
      end
      if (ce) begin
        ck_seq[ct[3:0]]   = seq;
        ck_valid[ct[3:0]] = 1'b1;
      end
    end
    if (push) free_q.push_back(po);
  endtask

  task automatic compare_model();
    check("free_count", 32'(fl.free_count), 32'(free_q.size()));
    check("full", 32'(fl.full), 32'(free_q.size() == DEPTH));
    check("empty", 32'(fl.empty), 32'(free_q.size() == 0));
    check("alloc_valid", 32'(fl.alloc_valid), 32'(free_q.size() != 0));
    if (free_q.size() > 0) check("pd_new", 32'(fl.pd_new), 32'(free_q[0]));
  endtask

  task automatic cycle(input bit a, input bit rv, input logic [6:0] po, input bit ce,
                       input logic [4:0] ct, input bit mp, input logic [4:0] mt);
    fl.alloc_req      = a;
    fl.retire_valid   = rv;
    fl.preg_old       = po;
    fl.ckpt_en        = ce;
    fl.ckpt_tag       = ct;
    fl.mispredict     = mp;
    fl.mispredict_tag = mt;
    model_step(a, rv, po, ce, ct, mp, mt);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 7'd0, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic retire(input logic [6:0] p);
    cycle(0, 1, p, 0, 5'd0, 0, 5'd0);
  endtask

  task automatic do_reset();
    reset             = 1'b0;
    fl.alloc_req      = 1'b0;
    fl.retire_valid   = 1'b0;
    fl.preg_old       = '0;
    fl.ckpt_en        = 1'b0;
    fl.ckpt_tag       = '0;
    fl.mispredict     = 1'b0;
    fl.mispredict_tag = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset release values, then three pops.
    do_reset();
    check("rst_pd_new", 32'(fl.pd_new), 32'd32);
    check("rst_free_count", 32'(fl.free_count), 32'd96);
    check("rst_full", 32'(fl.full), 32'd1);
    check("rst_empty", 32'(fl.empty), 32'd0);
    alloc_n(3);
    check("alloc3_pd_new", 32'(fl.pd_new), 32'd35);
    check("alloc3_count", 32'(fl.free_count), 32'd93);

    // Drain to empty, recycle through retire, then pop and push together.
    do_reset();
    alloc_n(96);
    check("drain_empty", 32'(fl.empty), 32'd1);
    check("drain_alloc_valid", 32'(fl.alloc_valid), 32'd0);
    alloc_n(1);
    check("empty_pop_ignored", 32'(fl.free_count), 32'd0);
    retire(7'h45);
    check("recycle_pd_new", 32'(fl.pd_new), 32'h45);
    check("recycle_count", 32'(fl.free_count), 32'd1);
    cycle(1, 1, 7'h46, 0, 5'd0, 0, 5'd0);
    check("popush_pd_new", 32'(fl.pd_new), 32'h46);
    check("popush_count", 32'(fl.free_count), 32'd1);

    // p0 is never pushed; a push while full is dropped without moving the tail.
    do_reset();
    alloc_n(1);
    retire(7'd0);
    check("p0_filter", 32'(fl.free_count), 32'd95);
    retire(7'h20);
    check("refill_count", 32'(fl.free_count), 32'd96);
    check("refill_full", 32'(fl.full), 32'd1);
    retire(7'h21);
    check("full_drop", 32'(fl.free_count), 32'd96);
    alloc_n(95);
    check("tail_kept_pd_new", 32'(fl.pd_new), 32'h20);
    check("tail_kept_count", 32'(fl.free_count), 32'd1);

    // Checkpoint on the branch's own allocation, two more pops, then flush.
    do_reset();
    cycle(1, 0, 7'd0, 1, 5'd3, 0, 5'd0);
    alloc_n(2);
    check("pre_flush_pd_new", 32'(fl.pd_new), 32'd35);
    cycle(1, 0, 7'd0, 0, 5'd0, 1, 5'd3);
    check("flush_pd_new", 32'(fl.pd_new), 32'd33);
    check("flush_count", 32'(fl.free_count), 32'd95);

    // Flush combined with a retire push; 0x10 lands behind 95 free pregs.
    do_reset();
    cycle(1, 0, 7'd0, 1, 5'd3, 0, 5'd0);
    alloc_n(2);
    cycle(0, 1, 7'h10, 0, 5'd0, 1, 5'd3);
    check("flush_push_count", 32'(fl.free_count), 32'd96);
    check("flush_push_pd_new", 32'(fl.pd_new), 32'd33);
    alloc_n(95);
    check("flush_push_tail", 32'(fl.pd_new), 32'h10);

    // Tag bit 4 is ignored when indexing snapshots (tag 19 aliases slot 3).
    do_reset();
    alloc_n(5);
    cycle(1, 0, 7'd0, 1, 5'd19, 0, 5'd0);
    alloc_n(4);
    cycle(0, 0, 7'd0, 0, 5'd0, 1, 5'd3);
    check("tag_alias_pd_new", 32'(fl.pd_new), 32'd38);

    // Randomized traffic with alternating pop-heavy / push-heavy phases so both
    // pointers wrap many times and the list visits empty and full.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bit         a, rv, ce, mp;
      logic [6:0] po;
      logic [4:0] ct, mt;
      int         r, sz;
      a  = ($urandom_range(0, 99) < (((n / 500) % 2 == 0) ? 65 : 35));
      rv = ($urandom_range(0, 99) < 50);
      po = ($urandom_range(0, 15) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      ce = ($urandom_range(0, 99) < 20);
      ct = 5'($urandom_range(0, 31));
      mt = 5'($urandom_range(0, 31));
      mp = 1'b0;
      if ($urandom_range(0, 99) < 5 && ck_valid[mt[3:0]]) begin
        // Only flush to snapshots a real ROB could still hold.
        r  = seq - ck_seq[mt[3:0]];
        sz = free_q.size() + ((rv && po != 7'd0 && free_q.size() < DEPTH) ? 1 : 0);
        if (r >= 0 && r < DEPTH && r <= pop_log.size() && sz + r <= DEPTH) mp = 1'b1;
      end
      cycle(a, rv, po, ce, ct, mp, mt);
      if (mp) for (int k = 0; k < 16; k++) ck_valid[k] = 1'b0;
    end

    // Asynchronous reset mid-cycle: outputs revert before the next clock edge.
    cycle(1, 0, 7'd0, 0, 5'd0, 0, 5'd0);
    #2;
    reset = 1'b0;
    #1;
    check("async_pd_new", 32'(fl.pd_new), 32'd32);
    check("async_count", 32'(fl.free_count), 32'd96);
    check("async_full", 32'(fl.full), 32'd1);
    check("async_empty", 32'(fl.empty), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    alloc_n(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
